// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-state encoding, default line timing and
// the clocks-per-bit helper used by both the transmit and receive engines.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ  = 27_000_000;
    localparam int DEFAULT_BAUD_RATE = 115_200;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    // Truncated clocks per bit, floored at 4 so the half-bit point stays
    // distinct from the start edge.
    function automatic int calc_cycle(input int clk_freq, input int baud_rate);
        int c;
        c = clk_freq / baud_rate;
        return (c < 4) ? 4 : c;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte handshake between the receive engine (master) and the UART register
// block (slave).
interface uart_receiver_if;

    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;

    modport master (
        output rx_data,
        output rx_data_valid,
        input  rx_data_ready
    );

    modport slave (
        input  rx_data,
        input  rx_data_valid,
        output rx_data_ready
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin plus one delay flop for
// falling-edge detection. All flops reset to the idle-high line level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive engine: mid-bit sampling FSM feeding a one-entry holding
// register with valid/ready handshake, framing-error and overrun pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE = DEFAULT_BAUD_RATE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_rx,
    uart_receiver_if.master  rx_if,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CYCLE = calc_cycle(CLK_FREQ, BAUD_RATE);
    localparam int HALF  = CYCLE / 2;
    localparam int CW    = $clog2(CYCLE);

    localparam logic [CW-1:0] CYCLE_LAST = CW'(CYCLE - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF - 1);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .rx_i   (uart_rx),
        .rx_s_o (rx_s),
        .fall_o (rx_fall)
    );

    rx_state_e     state_q;
    logic [CW-1:0] clk_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q;
    logic          frame_err_q;
    logic          overrun_q;

    // LSB-first line: each new bit enters at the top and moves right.
    assign shift_d = {rx_s, shift_q[7:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            // NOTE: a consume clears valid here, but a delivery later in this
            // block re-assigns it; the last non-blocking assignment wins.
            if (rx_valid_q && rx_if.rx_data_ready) begin
                rx_valid_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    clk_cnt_q <= '0;
                    if (rx_fall) begin
                        state_q <= START;
                    end
                end

                START: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end

                DATA: begin
                    if (clk_cnt_q == CYCLE_LAST) begin
                        clk_cnt_q <= '0;
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end

                STOP: begin
                    if (clk_cnt_q == CYCLE_LAST) begin
                        clk_cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= IDLE;
                            // Holding register is free if empty or emptied this edge.
                            if (!rx_valid_q || rx_if.rx_data_ready) begin
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end

                BREAK: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_if.rx_data       = rx_data_q;
    assign rx_if.rx_data_valid = rx_valid_q;
    assign frame_err           = frame_err_q;
    assign overrun             = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: vector table of single frames, hand
// sequences for handshake/reset corners, and randomized frames vs a byte queue.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int CYCLE = calc_cycle(DEFAULT_CLK_FREQ, DEFAULT_BAUD_RATE);
    localparam int HALF  = CYCLE / 2;
    localparam int LAT   = 2 + HALF + 9 * CYCLE;
    localparam int NRAND = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_rx = 1'b1;
    logic frame_err;
    logic overrun;

    uart_receiver_if rxif ();

    uart_receiver #(
        .CLK_FREQ  (DEFAULT_CLK_FREQ),
        .BAUD_RATE (DEFAULT_BAUD_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rx_if     (rxif),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int valid_cycles = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int t0 = 0;
    logic prev_valid = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc++;

    // Inputs change only on negedges; sampling 3 time units later sees the
    // values the next posedge will act on.
    always begin
        @(negedge clk);
        #3;
        if (!rst) begin
            if (rxif.rx_data_valid && !prev_valid) rise_cyc = cyc;
            if (rxif.rx_data_valid) valid_cycles++;
            if (rxif.rx_data_valid && rxif.rx_data_ready) got_q.push_back(rxif.rx_data);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
        end
        prev_valid = rxif.rx_data_valid;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [31:0] got_at(input int i);
        return (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_mon();
        got_q.delete();
        valid_cycles = 0;
        ferr_cnt = 0;
        ovr_cnt = 0;
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int len);
        uart_rx = b;
        repeat (len) @(negedge clk);
    endtask

    // A bad stop bit keeps the line low for two bit times before releasing it.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int len,
                              output int start_cyc);
        start_cyc = cyc;
        send_bit(1'b0, len);
        for (int i = 0; i < 8; i++) send_bit(d[i], len);
        send_bit(stop_ok, len);
        if (!stop_ok) send_bit(1'b0, len);
        uart_rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         glitch;
        int         exp_cnt;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b0, 1, 8'h55, 0};
        vecs[1] = '{8'hA3, 1'b1, 1'b1, 1, 8'hA3, 0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 0, 8'h00, 1};
        vecs[3] = '{8'h81, 1'b1, 1'b0, 1, 8'h81, 0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1, 8'h00, 0};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 1, 8'hFF, 0};

        rxif.rx_data_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_data", rxif.rx_data, 8'h00);
        check("rst_valid", rxif.rx_data_valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        rst = 1'b0;
        idle(CYCLE);

        // Single frames with ready held high.
        for (int v = 0; v < 6; v++) begin
            clear_mon();
            if (vecs[v].glitch) begin
                send_bit(1'b0, 60);
                idle(CYCLE);
                check($sformatf("v%0d_glitch_valid", v), valid_cycles, 0);
                check($sformatf("v%0d_glitch_ferr", v), ferr_cnt, 0);
            end
            send_frame(vecs[v].data, vecs[v].stop_ok, CYCLE, t0);
            idle(2 * CYCLE);
            check($sformatf("v%0d_count", v), got_q.size(), vecs[v].exp_cnt);
            check($sformatf("v%0d_valid_cycles", v), valid_cycles, vecs[v].exp_cnt);
            check($sformatf("v%0d_ferr", v), ferr_cnt, vecs[v].exp_ferr);
            check($sformatf("v%0d_ovr", v), ovr_cnt, 0);
            if (vecs[v].exp_cnt == 1) begin
                check($sformatf("v%0d_data", v), got_at(0), 32'(vecs[v].exp_data));
                check_range($sformatf("v%0d_latency", v), rise_cyc - t0, LAT - 1, LAT + 1);
            end
        end

        // Overrun: two back-to-back frames with ready low.
        clear_mon();
        rxif.rx_data_ready = 1'b0;
        send_frame(8'hA5, 1'b1, CYCLE, t0);
        send_frame(8'h5A, 1'b1, CYCLE, t0);
        idle(CYCLE);
        check("ovr_hold_data", rxif.rx_data, 8'hA5);
        check("ovr_hold_valid", rxif.rx_data_valid, 1'b1);
        check("ovr_pulses", ovr_cnt, 1);
        rxif.rx_data_ready = 1'b1;
        idle(CYCLE);
        check("ovr_drain_count", got_q.size(), 1);
        check("ovr_drain_data", got_at(0), 32'h0000_00A5);
        check("ovr_drain_valid", rxif.rx_data_valid, 1'b0);

        // Consume on the same edge as the next delivery.
        clear_mon();
        rxif.rx_data_ready = 1'b0;
        send_frame(8'h00, 1'b1, CYCLE, t0);
        fork
            send_frame(8'hFF, 1'b1, CYCLE, t0);
            begin
                repeat (LAT) @(negedge clk);
                rxif.rx_data_ready = 1'b1;
                @(negedge clk);
                rxif.rx_data_ready = 1'b0;
            end
        join
        idle(CYCLE);
        check("same_edge_ovr", ovr_cnt, 0);
        check("same_edge_data", rxif.rx_data, 8'hFF);
        check("same_edge_valid", rxif.rx_data_valid, 1'b1);
        rxif.rx_data_ready = 1'b1;
        idle(8);
        check("same_edge_count", got_q.size(), 2);
        check("same_edge_first", got_at(0), 32'h0000_0000);
        check("same_edge_second", got_at(1), 32'h0000_00FF);

        // Reset during data bit 4; the transmitter abandons the frame.
        clear_mon();
        send_bit(1'b0, CYCLE);
        for (int i = 0; i < 4; i++) send_bit(1'b1, CYCLE);
        send_bit(1'b0, HALF);
        rst = 1'b1;
        uart_rx = 1'b1;
        @(negedge clk);
        check("midrst_data", rxif.rx_data, 8'h00);
        check("midrst_valid", rxif.rx_data_valid, 1'b0);
        check("midrst_ferr", frame_err, 1'b0);
        check("midrst_ovr", overrun, 1'b0);
        rst = 1'b0;
        idle(2 * CYCLE);
        check("midrst_no_byte", got_q.size(), 0);
        send_frame(8'h7E, 1'b1, CYCLE, t0);
        idle(2 * CYCLE);
        check("midrst_next_count", got_q.size(), 1);
        check("midrst_next_data", got_at(0), 32'h0000_007E);

        // Random bytes, occasional bad stop bits, bit times within +/-2%.
        clear_mon();
        exp_q.delete();
        begin
            int exp_ferr;
            exp_ferr = 0;
            for (int n = 0; n < NRAND; n++) begin
                logic [7:0] d;
                logic       ok;
                int         len;
                d   = 8'($urandom_range(0, 255));
                ok  = ($urandom_range(0, 9) != 0);
                len = CYCLE - 4 + $urandom_range(0, 8);
                if (ok) exp_q.push_back(d);
                else exp_ferr++;
                send_frame(d, ok, len, t0);
                idle($urandom_range(0, CYCLE) + (ok ? 0 : 4));
            end
            idle(2 * CYCLE);
            check("rand_count", got_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                check($sformatf("rand_byte%0d", i), got_at(i), 32'(exp_q[i]));
            end
            check("rand_ferr", ferr_cnt, exp_ferr);
            check("rand_ovr", ovr_cnt, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
